// File: rtl/axi_resp_pkg.sv
// Shared constants, FSM state encodings and the request-legality helper for
// the AXI memory responder.
//   AXI_RESP_*   : BRESP/RRESP codes
//   AXI_BURST_*  : AxBURST codes
//   AXI_SIZE_16B : AxSIZE for a full 128-bit beat
//   w_state_e    : write FSM states
//   r_state_e    : read FSM states
package axi_resp_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_16B    = 3'd4;

    typedef enum logic [1:0] {
        WStIdle,
        WStData,
        WStResp
    } w_state_e;

    typedef enum logic {
        RStIdle,
        RStData
    } r_state_e;

    // Only full-width INCR bursts touch the memory; anything else is
    // consumed for its full length and answered with SLVERR.
    function automatic logic req_legal(input logic [1:0] burst, input logic [2:0] size);
        return (burst == AXI_BURST_INCR) && (size == AXI_SIZE_16B);
    endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle for the 128-bit test-traffic port.
//   AW : awid, awaddr, awlen, awsize, awburst, awvalid / awready
//   W  : wdata, wstrb, wlast, wvalid / wready
//   B  : bid, bresp, bvalid / bready
//   AR : arid, araddr, arlen, arsize, arburst, arvalid / arready
//   R  : rid, rdata, rresp, rlast, rvalid / rready
// Modports: master (traffic generator side), slave (responder side).
interface axi_mem_responder_if;

    logic [7:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;

    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;

    logic [7:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    logic [7:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;

    logic [7:0]   rid;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_mem_bytewe.sv
// 128-bit wide on-chip memory, 2^MEM_AW words deep.
//   clk     : clock
//   wr_be   : per-byte write enables (byte i = wr_data[8*i +: 8])
//   wr_addr : write word index
//   wr_data : write data
//   rd_en   : load rd_data from rd_addr on the next edge
//   rd_addr : read word index
//   rd_data : registered read data, holds while rd_en is low
// A same-cycle read and write of one word returns the old contents.
module axi_mem_bytewe #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic [15:0]       wr_be,
    input  logic [MEM_AW-1:0] wr_addr,
    input  logic [127:0]      wr_data,
    input  logic              rd_en,
    input  logic [MEM_AW-1:0] rd_addr,
    output logic [127:0]      rd_data
);

    localparam int unsigned DEPTH = 1 << MEM_AW;

    logic [127:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave that stands in for the DDR controller port 0: accepts INCR
// write bursts into a byte-enabled on-chip memory, returns read bursts and
// emulates the controller's init-done after INIT_CYCLES.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   init_done : emulated controller init-done (registered)
//   proto_err : sticky, set when wlast disagrees with the beat count
//   axi       : AXI4 slave bus (one outstanding transaction per direction)
module axi_mem_responder
    import axi_resp_pkg::*;
#(
    parameter int unsigned CTRL_ADDR_WIDTH = 28,
    parameter int unsigned MEM_AW          = 10,
    parameter int unsigned INIT_CYCLES     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_done,
    output logic              proto_err,
    axi_mem_responder_if.slave axi
);

    localparam int unsigned CNT_W = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;

    // ---------------------------------------------------------------- init
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic             init_done_q;

    always_comb begin
        init_cnt_d = init_cnt_q;
        if (init_cnt_q != CNT_W'(INIT_CYCLES)) begin
            init_cnt_d = init_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            init_done_q <= (init_cnt_d == CNT_W'(INIT_CYCLES));
        end
    end

    assign init_done = init_done_q;

    // ----------------------------------------------------- address decode
    logic [CTRL_ADDR_WIDTH-1:0] awaddr_used, araddr_used;
    logic [MEM_AW-1:0]          aw_idx, ar_idx;
    logic                       unused_addr;

    assign awaddr_used = axi.awaddr[CTRL_ADDR_WIDTH-1:0];
    assign araddr_used = axi.araddr[CTRL_ADDR_WIDTH-1:0];
    assign aw_idx      = awaddr_used[4 +: MEM_AW];
    assign ar_idx      = araddr_used[4 +: MEM_AW];
    // Byte offset and bits above the word index are deliberately ignored.
    assign unused_addr = ^{axi.awaddr, axi.araddr, awaddr_used, araddr_used};

    // ------------------------------------------------------------- memory
    logic [15:0]       mem_wr_be;
    logic              mem_rd_en;
    logic [MEM_AW-1:0] mem_rd_addr;
    logic [127:0]      mem_rd_data;

    // ---------------------------------------------------------- write FSM
    w_state_e          w_state_q, w_state_d;
    logic              aw_ready, w_ready, b_valid;
    logic              aw_hs, w_hs, w_last_beat;
    logic [7:0]        bid_q;
    logic [MEM_AW-1:0] w_idx_q;
    logic [8:0]        w_left_q;
    logic              w_err_q;
    logic              proto_err_q;

    assign aw_hs       = axi.awvalid & aw_ready;
    assign w_hs        = axi.wvalid & w_ready;
    assign w_last_beat = (w_left_q == 9'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= WStIdle;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            WStIdle: if (aw_hs) w_state_d = WStData;
            WStData: if (w_hs && w_last_beat) w_state_d = WStResp;
            WStResp: if (axi.bready) w_state_d = WStIdle;
            default: w_state_d = WStIdle;
        endcase
    end

    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        unique case (w_state_q)
            WStIdle: aw_ready = init_done_q;
            WStData: w_ready  = 1'b1;
            WStResp: b_valid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bid_q       <= '0;
            w_idx_q     <= '0;
            w_left_q    <= '0;
            w_err_q     <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            if (aw_hs) begin
                bid_q    <= axi.awid;
                w_idx_q  <= aw_idx;
                w_left_q <= {1'b0, axi.awlen} + 9'd1;
                w_err_q  <= ~req_legal(axi.awburst, axi.awsize);
            end
            if (w_hs) begin
                w_idx_q  <= w_idx_q + MEM_AW'(1);
                w_left_q <= w_left_q - 9'd1;
                // The beat count ends the burst; wlast is only cross-checked.
                if (axi.wlast != w_last_beat) begin
                    proto_err_q <= 1'b1;
                end
            end
        end
    end

    assign mem_wr_be   = (w_hs && !w_err_q) ? axi.wstrb : 16'h0000;
    assign axi.awready = aw_ready;
    assign axi.wready  = w_ready;
    assign axi.bvalid  = b_valid;
    assign axi.bid     = bid_q;
    assign axi.bresp   = (b_valid && w_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign proto_err   = proto_err_q;

    // ----------------------------------------------------------- read FSM
    r_state_e          r_state_q, r_state_d;
    logic              ar_ready, r_valid;
    logic              ar_hs, r_hs, r_last_beat;
    logic [7:0]        rid_q;
    logic [MEM_AW-1:0] r_idx_q;
    logic [8:0]        r_left_q;
    logic              r_err_q;

    assign ar_hs       = axi.arvalid & ar_ready;
    assign r_hs        = r_valid & axi.rready;
    assign r_last_beat = (r_left_q == 9'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= RStIdle;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            RStIdle: if (ar_hs) r_state_d = RStData;
            RStData: if (r_hs && r_last_beat) r_state_d = RStIdle;
            default: r_state_d = RStIdle;
        endcase
    end

    always_comb begin
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        unique case (r_state_q)
            RStIdle: ar_ready = init_done_q;
            RStData: r_valid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rid_q    <= '0;
            r_idx_q  <= '0;
            r_left_q <= '0;
            r_err_q  <= 1'b0;
        end else begin
            if (ar_hs) begin
                rid_q    <= axi.arid;
                r_idx_q  <= ar_idx;
                r_left_q <= {1'b0, axi.arlen} + 9'd1;
                r_err_q  <= ~req_legal(axi.arburst, axi.arsize);
            end
            if (r_hs) begin
                r_idx_q  <= r_idx_q + MEM_AW'(1);
                r_left_q <= r_left_q - 9'd1;
            end
        end
    end

    // The memory output register is the rdata register: it is loaded with
    // beat 0 on the AR handshake and with the next word on each accepted
    // beat, and otherwise holds, so rdata is stable under backpressure.
    assign mem_rd_en   = ar_hs | (r_hs & ~r_last_beat);
    assign mem_rd_addr = (r_state_q == RStIdle) ? ar_idx : (r_idx_q + MEM_AW'(1));

    assign axi.arready = ar_ready;
    assign axi.rvalid  = r_valid;
    assign axi.rid     = rid_q;
    assign axi.rlast   = r_valid & r_last_beat;
    assign axi.rresp   = (r_valid && r_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    // Gating keeps rdata at 0 out of reset and for illegal reads without
    // having to reset the memory output register.
    assign axi.rdata   = (r_valid && !r_err_q) ? mem_rd_data : 128'h0;

    axi_mem_bytewe #(
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .wr_be   (mem_wr_be),
        .wr_addr (w_idx_q),
        .wr_data (axi.wdata),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data)
    );

endmodule

// File: tb/tb_axi_mem_responder.sv
`timescale 1ns/1ps
module tb_axi_mem_responder;

    logic clk;
    logic rst_n;
    logic init_done;
    logic proto_err;

    axi_mem_responder_if bus ();

    axi_mem_responder #(
        .CTRL_ADDR_WIDTH (28),
        .MEM_AW          (10),
        .INIT_CYCLES     (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .proto_err (proto_err),
        .axi       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic [7:0]   id;
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } rbeat_t;

    rbeat_t       exp_q[$];
    logic [127:0] model_mem [1024];

    typedef struct {
        logic [7:0]   id;
        logic [31:0]  addr;
        logic [31:0]  raddr;
        logic [127:0] wdata;
        logic [15:0]  wstrb;
        logic [1:0]   awburst;
        logic [2:0]   awsize;
        logic [1:0]   arburst;
        logic [2:0]   arsize;
        logic [1:0]   exp_bresp;
        logic [127:0] exp_rdata;
        logic [1:0]   exp_rresp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                             input logic legal);
        logic [9:0] idx;
        rbeat_t     e;
        idx = addr[13:4];
        for (int b = 0; b <= len; b++) begin
            e.id   = id;
            e.data = legal ? model_mem[idx] : 128'h0;
            e.resp = legal ? 2'b00 : 2'b10;
            e.last = (b == len);
            exp_q.push_back(e);
            idx = idx + 10'd1;
        end
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic [127:0] base, input logic [15:0] strb,
                            input int wlast_beat, input logic [1:0] exp_bresp);
        int           k;
        logic         legal;
        logic [9:0]   idx;
        logic [127:0] d;
        legal = (burst == 2'b01) && (size == 3'd4);
        idx   = addr[13:4];
        bus.awid    = id;
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awburst = burst;
        bus.awvalid = 1'b1;
        k = 0;
        while (bus.awready !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("aw_accept", bus.awready, 1'b1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            d = base + 128'(b);
            bus.wdata  = d;
            bus.wstrb  = strb;
            bus.wlast  = (b == wlast_beat);
            bus.wvalid = 1'b1;
            k = 0;
            while (bus.wready !== 1'b1 && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            check("w_ready", bus.wready, 1'b1);
            @(posedge clk); #1;
            if (legal) begin
                for (int i = 0; i < 16; i++) begin
                    if (strb[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
                end
            end
            idx = idx + 10'd1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        check("b_valid_timing", bus.bvalid, 1'b1);
        check("b_id", bus.bid, id);
        check("b_resp", bus.bresp, exp_bresp);
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        check("b_valid_drop", bus.bvalid, 1'b0);
        check("aw_ready_after_b", bus.awready, 1'b1);
    endtask

    // Expectations must already be queued; each beat is compared against the
    // queue head on every cycle rvalid is high and popped on the handshake.
    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input logic toggle);
        int     k;
        int     cyc;
        rbeat_t e;
        bus.arid    = id;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        k = 0;
        while (bus.arready !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("ar_accept", bus.arready, 1'b1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        check("r_valid_timing", bus.rvalid, 1'b1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            bus.rready = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (bus.rvalid) begin
                e = exp_q[0];
                check("r_data", bus.rdata, e.data);
                check("r_last", bus.rlast, e.last);
                check("r_id", bus.rid, e.id);
                check("r_resp", bus.rresp, e.resp);
                if (bus.rready) void'(exp_q.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.rready = 1'b0;
        check("r_drained", exp_q.size(), 0);
        check("r_no_extra", bus.rvalid, 1'b0);
        check("ar_ready_after_r", bus.arready, 1'b1);
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic   early;
        int     k;
        rbeat_t e;

        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{8'h5A, 32'h10, 32'h10, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF,
                    2'b01, 3'd4, 2'b01, 3'd4, 2'b00,
                    128'h0123456789ABCDEF0123456789ABCDEF, 2'b00};
        vecs[1] = '{8'h11, 32'h200, 32'h200, {128{1'b1}}, 16'hFFFF,
                    2'b01, 3'd4, 2'b01, 3'd4, 2'b00, {128{1'b1}}, 2'b00};
        vecs[2] = '{8'h12, 32'h200, 32'h200, 128'h0, 16'h00F0,
                    2'b01, 3'd4, 2'b01, 3'd4, 2'b00,
                    128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF, 2'b00};
        vecs[3] = '{8'h13, 32'h200, 32'h200, 128'h12345678_12345678_12345678_12345678, 16'hFFFF,
                    2'b10, 3'd4, 2'b01, 3'd4, 2'b10,
                    128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF, 2'b00};
        vecs[4] = '{8'h14, 32'h10, 32'h10, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'hFFFF,
                    2'b01, 3'd3, 2'b01, 3'd4, 2'b10,
                    128'h0123456789ABCDEF0123456789ABCDEF, 2'b00};
        vecs[5] = '{8'h15, 32'h20, 32'h20, 128'h55555555_55555555_55555555_55555555, 16'hFFFF,
                    2'b01, 3'd4, 2'b00, 3'd4, 2'b00, 128'h0, 2'b10};
        vecs[6] = '{8'h16, 32'hF000_0040, 32'h40, 128'hDEADBEEF_CAFEF00D_01020304_A5A5A5A5, 16'hFFFF,
                    2'b01, 3'd4, 2'b01, 3'd4, 2'b00,
                    128'hDEADBEEF_CAFEF00D_01020304_A5A5A5A5, 2'b00};

        rst_n       = 1'b0;
        bus.awid    = '0; bus.awaddr  = '0; bus.awlen   = '0; bus.awsize = 3'd4;
        bus.awburst = 2'b01; bus.awvalid = 1'b0;
        bus.wdata   = '0; bus.wstrb   = '0; bus.wlast   = 1'b0; bus.wvalid = 1'b0;
        bus.bready  = 1'b0;
        bus.arid    = '0; bus.araddr  = '0; bus.arlen   = '0; bus.arsize = 3'd4;
        bus.arburst = 2'b01; bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", init_done, 1'b0);
        check("rst_awready", bus.awready, 1'b0);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_wready", bus.wready, 1'b0);
        check("rst_bvalid", bus.bvalid, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        check("rst_rdata", bus.rdata, 128'h0);

        // Init delay with awvalid held high
        rst_n       = 1'b1;
        bus.awvalid = 1'b1;
        early       = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            if (c < 64 && (bus.awready !== 1'b0 || init_done !== 1'b0)) early = 1'b1;
        end
        bus.awvalid = 1'b0;
        check("init_ready_early", early, 1'b0);
        check("init_done_64", init_done, 1'b1);
        check("init_awready_64", bus.awready, 1'b1);
        check("init_arready_64", bus.arready, 1'b1);

        // Single-beat write/read vectors
        for (int v = 0; v < 7; v++) begin
            do_write(vecs[v].id, vecs[v].addr, 8'd0, vecs[v].awburst, vecs[v].awsize,
                     vecs[v].wdata, vecs[v].wstrb, 0, vecs[v].exp_bresp);
            e.id   = vecs[v].id;
            e.data = vecs[v].exp_rdata;
            e.resp = vecs[v].exp_rresp;
            e.last = 1'b1;
            exp_q.push_back(e);
            do_read(vecs[v].id, vecs[v].raddr, 8'd0, vecs[v].arburst, vecs[v].arsize, 1'b0);
        end

        // Wrap-around from word 1022
        do_write(8'h41, 32'h3FE0, 8'd3, 2'b01, 3'd4,
                 128'hC0DE0000_11112222_33334444_55550000, 16'hFFFF, 3, 2'b00);
        push_read(8'h42, 32'h3FE0, 3, 1'b1);
        do_read(8'h42, 32'h3FE0, 8'd3, 2'b01, 3'd4, 1'b0);
        push_read(8'h43, 32'h0, 1, 1'b1);
        do_read(8'h43, 32'h0, 8'd1, 2'b01, 3'd4, 1'b0);

        // 8-beat read with rready toggling
        do_write(8'h21, 32'h1000, 8'd7, 2'b01, 3'd4,
                 128'h80000000_00000000_00000000_00000100, 16'hFFFF, 7, 2'b00);
        push_read(8'h22, 32'h1000, 7, 1'b1);
        do_read(8'h22, 32'h1000, 8'd7, 2'b01, 3'd4, 1'b1);

        // Early wlast: full beat count still consumed, proto_err latched
        check("proto_err_before", proto_err, 1'b0);
        do_write(8'h31, 32'h2000, 8'd3, 2'b01, 3'd4,
                 128'h0BAD0000_00000000_00000000_00000000, 16'hFFFF, 1, 2'b00);
        check("proto_err_set", proto_err, 1'b1);
        push_read(8'h32, 32'h2000, 3, 1'b1);
        do_read(8'h32, 32'h2000, 8'd3, 2'b01, 3'd4, 1'b0);
        check("proto_err_sticky", proto_err, 1'b1);

        // Reset after 2 of 8 read beats
        push_read(8'h77, 32'h1000, 7, 1'b1);
        bus.arid    = 8'h77;
        bus.araddr  = 32'h1000;
        bus.arlen   = 8'd7;
        bus.arsize  = 3'd4;
        bus.arburst = 2'b01;
        bus.arvalid = 1'b1;
        k = 0;
        while (bus.arready !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("mid_ar_accept", bus.arready, 1'b1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        for (int b = 0; b < 2; b++) begin
            e = exp_q[0];
            check("mid_r_valid", bus.rvalid, 1'b1);
            check("mid_r_data", bus.rdata, e.data);
            void'(exp_q.pop_front());
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", bus.rvalid, 1'b0);
        check("mid_rst_rlast", bus.rlast, 1'b0);
        check("mid_rst_rdata", bus.rdata, 128'h0);
        check("mid_rst_arready", bus.arready, 1'b0);
        check("mid_rst_init_done", init_done, 1'b0);
        check("mid_rst_proto_err", proto_err, 1'b0);
        exp_q.delete();
        bus.rready = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("rst_hold_rvalid", bus.rvalid, 1'b0);
        rst_n = 1'b1;
        k = 0;
        while (init_done !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("reinit_cycles", k, 64);
        check("reinit_rvalid", bus.rvalid, 1'b0);
        check("reinit_bvalid", bus.bvalid, 1'b0);
        push_read(8'h78, 32'h1000, 7, 1'b1);
        do_read(8'h78, 32'h1000, 8'd7, 2'b01, 3'd4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 slave responder that terminates the 128-bit test-traffic port driven by `test_wr_ctrl_128bit` and `test_rd_ctrl_128bit`, standing in for the DDR3 controller's port 0. It accepts INCR bursts into a byte-enabled on-chip memory and returns read bursts. It emulates `ddrc_init_done` after a programmable delay. The whole traffic generator and checker can then run without the hard memory controller, either in simulation or on a board with no DDR fitted.

## Interface
- `CTRL_ADDR_WIDTH`, 28: width of the `axi_awaddr`/`axi_araddr` bits that are used; upper address bits are ignored.
- `MEM_AW`, 10: log2 of memory depth in 128-bit words.
- `INIT_CYCLES`, 64: number of cycles from reset release to `init_done`.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `init_done` out 1: emulated `ddrc_init_done`.
- `axi_awid` in 8, `axi_awaddr` in 32, `axi_awlen` in 8, `axi_awsize` in 3, `axi_awburst` in 2, `axi_awvalid` in 1, `axi_awready` out 1: write address channel.
- `axi_wdata` in 128, `axi_wstrb` in 16, `axi_wlast` in 1, `axi_wvalid` in 1, `axi_wready` out 1: write data channel.
- `axi_bid` out 8, `axi_bresp` out 2, `axi_bvalid` out 1, `axi_bready` in 1: write response channel.
- `axi_arid` in 8, `axi_araddr` in 32, `axi_arlen` in 8, `axi_arsize` in 3, `axi_arburst` in 2, `axi_arvalid` in 1, `axi_arready` out 1: read address channel.
- `axi_rid` out 8, `axi_rdata` out 128, `axi_rresp` out 2, `axi_rlast` out 1, `axi_rvalid` out 1, `axi_rready` in 1: read data channel.
- `proto_err` out 1: sticky flag for a `wlast` mismatch; cleared only by reset.

## Operation
- **Reset:** every output is 0, both FSMs are in IDLE, and the init counter is 0. Memory contents are not reset.
- **Init:** the counter saturates at `INIT_CYCLES`. `init_done` is registered and rises on the cycle the counter reaches `INIT_CYCLES`. `axi_awready` and `axi_arready` stay 0 until then.
- **Word index:** `addr[4 +: MEM_AW]`. The index increments by 1 per beat and wraps modulo 2^MEM_AW.
- **Legal request:** `awburst`/`arburst` = 2'b01 (INCR) and `awsize`/`arsize` = 3'd4. Any other request is still accepted and run for the full `len+1` beats, but:
  - write: no memory update, `bresp` = 2'b10 (SLVERR);
  - read: `rdata` = 0, `rresp` = 2'b10 on every beat.
  - Legal requests return OKAY (2'b00).
- **Write FSM:**
  - W_IDLE: `awready`=1. An AW handshake latches id, index, `len+1` and the error flag, then goes to W_DATA.
  - W_DATA: `wready`=1. Each beat writes the bytes of `wdata` enabled by `wstrb[i]` (byte i). After the final counted beat, go to W_RESP.
  - W_RESP: `bvalid`=1 and held until `bready`, then go to W_IDLE.
  - The beat count, not `wlast`, ends the burst. If `wlast` is high on a non-final beat, or low on the final beat, `proto_err` is set.
- **Read FSM:**
  - R_IDLE: `arready`=1. An AR handshake latches id, index, `len+1` and the error flag, loads beat 0 into the registered `rdata`, and goes to R_DATA.
  - R_DATA: `rvalid`=1. `rdata`, `rlast`, `rid` and `rresp` are held stable while `rready`=0.
  - On a beat handshake, the next word is loaded. After the last beat, go to R_IDLE.
- **Channel independence:** the read and write FSMs run concurrently. If a read and a write hit the same word in the same cycle, the read returns the old data.
- **Outstanding transactions:** only one transaction per direction is outstanding. There is no interleaving, and the ID is echoed unchanged.

## Timing
- AW handshake at cycle N: `wready` is high from N+1. With `wvalid` held high, a burst of L beats is accepted in cycles N+1..N+L. `bvalid` rises at N+L+1. `awready` is 1 again on the cycle after the B handshake.
- AR handshake at cycle N: first `rvalid` at N+1. With `rready`=1, one beat per cycle, and `rlast` on beat N+len+1. `arready` is 1 again the cycle after the last beat.
- Written data is visible to a read whose AR handshake occurs on the cycle after the write beat, or later.
- `rst_n` asserted mid-burst: everything returns to reset values at once. The remaining beats are dropped, and no B or R response is produced.

## Structure
- Package `axi_resp_pkg` holds:
  - constants `AXI_RESP_OKAY`, `AXI_RESP_SLVERR`, `AXI_BURST_INCR`, `AXI_SIZE_16B`;
  - write-FSM and read-FSM state encodings.
- Sub-module `axi_mem_bytewe`: 128-bit × 2^MEM_AW memory with one byte-enabled write port and one synchronous read port. The two FSMs stay in the top module.

## Test plan
- **Init:** release reset and hold `awvalid`=1 → `awready`=0 for the first 64 cycles; `init_done` and `awready` are 1 at cycle 64.
- **Single write then read:** write 1 beat to addr 0x10 with data `0x0123…CDEF` and `wstrb`=16'hFFFF, `awid`=8'h5A → `bid`=8'h5A, `bresp`=0. Then read addr 0x10 with `arlen`=0 → matching `rdata`, `rlast`=1, `rid`=8'h5A.
- **Wrap-around:** INCR write with `awlen`=3 at word index 1022 with `MEM_AW`=10 → the burst writes words 1022, 1023, 0, 1. A 4-beat read at the same address returns those words in order.
- **Byte strobes and backpressure:** overwrite a 0xFF-filled word with `wstrb`=16'h00F0 and data 0 → only bytes 4..7 read back as 0x00. Toggle `rready` every other cycle during an 8-beat read → no beat lost or duplicated, and `rdata` is stable while stalled.
- **Errors:** `awburst`=2'b10 → memory unchanged and `bresp`=2'b10. A 4-beat write with `wlast` on beat 2 → 4 beats still consumed and `proto_err`=1.
- **Reset mid-burst:** assert `rst_n` low after 2 of 8 read beats → `rvalid`=0 immediately. After re-init, a new read returns the previously written data.
